// File: rtl/tinyenc_arb.sv
`default_nettype none
// ============================================================================
// Module      : tinyenc_arb
// Description : Round-robin arbiter/sequencer sharing one tinyenc engine among
//               N requesters, with a per-job watchdog and post-abort drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tinyenc_arb #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [N-1:0]      req_valid,
    input  logic [N*32-1:0]   req_data,
    output logic [N-1:0]      req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              eng_req,
    output logic [31:0]       eng_wdata,
    input  logic              eng_ack,
    input  logic [31:0]       eng_rdata,
    output logic              busy
);

    localparam int             WDW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam int             PW      = 2 ** IDW;

    typedef enum logic [2:0] {
        DRAIN = 3'd0,
        IDLE  = 3'd1,
        ISSUE = 3'd2,
        BUSY  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           drain_q, drain_d;
    logic           eng_req_q, eng_req_d;
    logic [31:0]    eng_wdata_q, eng_wdata_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]    rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;

    logic [PW-1:0]  w_valid_pad;
    logic           w_found;
    logic [IDW-1:0] w_win;
    logic [31:0]    w_win_data;
    logic           w_grant_en;
    logic           w_wd_expired;

    // Search order is ptr+1, ptr+2, ... wrapping at N, so the last winner is
    // visited last.
    always_comb begin
        w_valid_pad          = '0;
        w_valid_pad[N-1:0]   = req_valid;
        w_found              = 1'b0;
        w_win                = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && w_valid_pad[IDW'((int'(ptr_q) + k) % N)]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == IDW'(i)) begin
                w_win_data = req_data[32*i +: 32];
            end
        end
    end

    assign w_grant_en   = (state_q == IDLE) && w_found;
    assign w_wd_expired = (wd_q == WD_LAST);

    for (genvar gi = 0; gi < N; gi++) begin : g_req_ready
        assign req_ready[gi] = w_grant_en && (w_win == IDW'(gi));
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= DRAIN;
            ptr_q       <= IDW'(N - 1);
            wd_q        <= '0;
            drain_q     <= 1'b0;
            eng_req_q   <= 1'b0;
            eng_wdata_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wd_q        <= wd_d;
            drain_q     <= drain_d;
            eng_req_q   <= eng_req_d;
            eng_wdata_q <= eng_wdata_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wd_d        = wd_q;
        drain_d     = drain_q;
        eng_req_d   = eng_req_q;
        eng_wdata_d = eng_wdata_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            DRAIN: begin
                if (eng_ack) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (w_found) begin
                    eng_wdata_d = w_win_data;
                    eng_req_d   = 1'b1;
                    rsp_id_d    = w_win;
                    ptr_d       = w_win;
                    wd_d        = '0;
                    drain_d     = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE, BUSY: begin
                wd_d = wd_q + 1'b1;
                // The watchdog wins over a completion in the same cycle; the
                // engine may still hold the job, so drain before the next grant.
                if (w_wd_expired) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    eng_req_d  = 1'b0;
                    drain_d    = 1'b1;
                    state_d    = RESP;
                end else if (state_q == ISSUE) begin
                    if (!eng_ack) begin
                        eng_req_d = 1'b0;
                        state_d   = BUSY;
                    end
                end else if (eng_ack) begin
                    rsp_data_d = eng_rdata;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = drain_q ? DRAIN : IDLE;
                end
            end
            default: begin
                state_d = DRAIN;
            end
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign eng_req   = eng_req_q;
    assign eng_wdata = eng_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tinyenc_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_tinyenc_arb
// Description : Directed bench for tinyenc_arb with a behavioural engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tinyenc_arb;

    localparam int          N       = 4;
    localparam int          IDW     = 2;
    localparam int          TIMEOUT = 64;
    localparam int          R       = 8;
    localparam logic [63:0] KEY     = 64'h816fc52b09e74da3;
    localparam logic [15:0] DELTA   = 16'd1;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              eng_rstb = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*32-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              eng_req;
    logic [31:0]       eng_wdata;
    logic              eng_ack;
    logic [31:0]       eng_rdata;
    logic              busy;
    logic              psel = 1'b0;
    logic [31:0]       words [N];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = words[i];
    end

    tinyenc_arb #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .eng_req(eng_req), .eng_wdata(eng_wdata), .eng_ack(eng_ack),
        .eng_rdata(eng_rdata), .busy(busy)
    );

    // Reference round function: 16-bit halves, 64-bit key, R rounds.
    function automatic logic [31:0] enc(input logic [31:0] w);
        logic [63:0] k;
        logic [15:0] v0, v1, s;
        k = KEY; v0 = w[15:0]; v1 = w[31:16]; s = '0;
        for (int r = 0; r < R; r++) begin
            s  = s + DELTA;
            v0 = v0 + ((16'(v1 << 4) + k[15:0]) ^ (v1 + s) ^ ((v1 >> 5) + k[31:16]));
            v1 = v1 + ((16'(v0 << 4) + k[47:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[63:48]));
        end
        return {v1, v0};
    endfunction

    // Engine: ack drops combinationally when it takes req; psel stalls it idle.
    logic        eng_busy_q;
    logic [3:0]  eng_cnt_q;
    logic [31:0] eng_word_q, eng_rdata_q;
    assign eng_ack   = !eng_busy_q && !(eng_req && !psel);
    assign eng_rdata = eng_rdata_q;

    always_ff @(posedge clk or negedge eng_rstb) begin
        if (!eng_rstb) begin
            eng_busy_q  <= 1'b0;
            eng_cnt_q   <= '0;
            eng_word_q  <= '0;
            eng_rdata_q <= '0;
        end else if (!eng_busy_q) begin
            if (eng_req && !psel) begin
                eng_busy_q <= 1'b1;
                eng_cnt_q  <= 4'(R - 1);
                eng_word_q <= eng_wdata;
            end
        end else if (eng_cnt_q == 4'd0) begin
            eng_busy_q  <= 1'b0;
            eng_rdata_q <= enc(eng_word_q);
        end else begin
            eng_cnt_q <= eng_cnt_q - 4'd1;
        end
    end

    task automatic wait_grant(input int bound, output bit ok);
        ok = 1'b0;
        #1;
        for (int k = 0; k < bound; k++) begin
            if (req_ready != '0) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_rsp(input int bound, output bit ok);
        ok = 1'b0;
        #1;
        for (int k = 0; k < bound; k++) begin
            if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rstb = 1'b0; eng_rstb = 1'b0; psel = 1'b0;
        req_valid = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstb = 1'b1; eng_rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) words[i] = 32'hA5A5_0000 + 32'(i);
        req_valid = '1;
        @(negedge clk); #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        checks++; if (eng_req !== 1'b0) begin errors++; $display("FAIL rst_eng_req: got %b want 0", eng_req); end
        checks++; if (eng_wdata !== 32'h0) begin errors++; $display("FAIL rst_eng_wdata: got %h want 0", eng_wdata); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
        rstb = 1'b1; eng_rstb = 1'b1;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_prio: got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        bit ok;
        int t0;
        words[2] = 32'h0000_0000; req_valid = 4'b0100; rsp_ready = 1'b0;
        wait_grant(20, ok);
        t0 = cyc;
        checks++; if (!ok || req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        @(negedge clk); #1; req_valid = '0;
        checks++; if (eng_req !== 1'b1 || busy !== 1'b1 || req_ready !== '0) begin errors++; $display("FAIL single_issue: got eng_req=%b busy=%b req_ready=%b want 1 1 0", eng_req, busy, req_ready); end
        @(negedge clk); #1;
        checks++; if (eng_req !== 1'b0) begin errors++; $display("FAIL single_busy_req: got %b want 0", eng_req); end
        wait_rsp(30, ok);
        checks++; if (!ok || (cyc - t0) !== 11) begin errors++; $display("FAIL single_latency: got %0d want 11", cyc - t0); end
        checks++; if (rsp_id !== 2'd2 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_id_err: got id=%0d err=%b want 2 0", rsp_id, rsp_err); end
        checks++; if (rsp_data !== enc(32'h0)) begin errors++; $display("FAIL single_data: got %h want %h", rsp_data, enc(32'h0)); end
        rsp_ready = 1'b1;
        @(negedge clk); #1; rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_fairness();
        bit ok;
        int tprev, ex;
        logic [N-1:0] oh;
        do_reset();
        words[0] = 32'hAAAA_0000; words[1] = 32'hBBBB_0001;
        words[2] = 32'hCCCC_0002; words[3] = 32'hDDDD_0003;
        req_valid = '1; rsp_ready = 1'b1; tprev = 0;
        for (int g = 0; g < 6; g++) begin
            ex = g % N; oh = '0; oh[ex] = 1'b1;
            wait_grant(20, ok);
            checks++; if (!ok || req_ready !== oh) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", g, req_ready, oh); end
            if (g > 0) begin
                checks++; if ((cyc - tprev) !== R + 4) begin errors++; $display("FAIL fair_tput%0d: got %0d want %0d", g, cyc - tprev, R + 4); end
            end
            tprev = cyc;
            @(negedge clk);
            wait_rsp(30, ok);
            checks++; if (!ok || rsp_id !== IDW'(ex) || rsp_data !== enc(words[ex]) || rsp_err !== 1'b0) begin errors++; $display("FAIL fair_rsp%0d: got id=%0d data=%h want id=%0d data=%h", g, rsp_id, rsp_data, ex, enc(words[ex])); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = '1;
        wait_grant(20, ok);
        checks++; if (!ok || req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        wait_rsp(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_rsp_timeout: got rsp_valid=%b want 1", rsp_valid); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            bad = (rsp_valid !== 1'b1) || (rsp_id !== 2'd2) || (rsp_data !== enc(words[2])) || (req_ready !== '0) || (rsp_err !== 1'b0);
            checks++; if (bad) begin errors++; $display("FAIL bp_hold%0d: got v=%b id=%0d data=%h rr=%b want 1 2 %h 0", k, rsp_valid, rsp_id, rsp_data, req_ready, enc(words[2])); end
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant: got %b want 1000", req_ready); end
        @(negedge clk); req_valid = '0;
        wait_rsp(30, ok);
        checks++; if (!ok || rsp_id !== 2'd3 || rsp_data !== enc(words[3])) begin errors++; $display("FAIL bp_next_rsp: got id=%0d data=%h want 3 %h", rsp_id, rsp_data, enc(words[3])); end
        @(negedge clk); rsp_ready = 1'b0;
    endtask

    task automatic test_stall();
        bit ok;
        bit bad;
        int t0;
        psel = 1'b1; words[0] = 32'h1234_5678; req_valid = 4'b0001; rsp_ready = 1'b0;
        wait_grant(20, ok);
        checks++; if (!ok || req_ready !== 4'b0001) begin errors++; $display("FAIL stall_grant: got %b want 0001", req_ready); end
        @(negedge clk); #1; req_valid = '0;
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (eng_req !== 1'b1 || eng_ack !== 1'b1 || eng_wdata !== 32'h1234_5678 || busy !== 1'b1) bad = 1'b1;
            @(negedge clk); #1;
        end
        checks++; if (bad) begin errors++; $display("FAIL stall_hold: got eng_req=%b eng_ack=%b wdata=%h want 1 1 12345678", eng_req, eng_ack, eng_wdata); end
        psel = 1'b0;
        wait_rsp(40, ok);
        checks++; if (!ok || rsp_id !== 2'd0 || rsp_err !== 1'b0 || rsp_data !== enc(32'h1234_5678)) begin errors++; $display("FAIL stall_rsp: got id=%0d err=%b data=%h want 0 0 %h", rsp_id, rsp_err, rsp_data, enc(32'h1234_5678)); end
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;

        psel = 1'b1; words[1] = 32'h0BAD_BEEF; req_valid = 4'b0010;
        wait_grant(20, ok);
        t0 = cyc;
        checks++; if (!ok || req_ready !== 4'b0010) begin errors++; $display("FAIL to_grant: got %b want 0010", req_ready); end
        @(negedge clk); req_valid = '0;
        wait_rsp(100, ok);
        checks++; if (!ok || (cyc - t0) !== TIMEOUT + 1) begin errors++; $display("FAIL to_latency: got %0d want %0d", cyc - t0, TIMEOUT + 1); end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_id !== 2'd1 || eng_req !== 1'b0) begin errors++; $display("FAIL to_rsp: got err=%b data=%h id=%0d eng_req=%b want 1 0 1 0", rsp_err, rsp_data, rsp_id, eng_req); end
        req_valid = 4'b0100; rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b1 || req_ready !== '0) begin errors++; $display("FAIL to_drain: got busy=%b req_ready=%b want 1 0", busy, req_ready); end
        psel = 1'b0; rsp_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL to_after_drain: got %b want 0100", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_reset_midjob();
        bit ok;
        bit bad;
        bit saw_ack;
        int t0;
        words[2] = 32'hCAFE_F00D; req_valid = 4'b0100; rsp_ready = 1'b0;
        wait_grant(20, ok);
        t0 = cyc;
        checks++; if (!ok || req_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant: got %b want 0100", req_ready); end
        repeat (6) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1 || eng_req !== 1'b0 || (cyc - t0) !== 6) begin errors++; $display("FAIL mid_busy5: got busy=%b eng_req=%b dt=%0d want 1 0 6", busy, eng_req, cyc - t0); end
        rstb = 1'b0; #1;
        bad = (rsp_valid !== 1'b0) || (rsp_id !== '0) || (rsp_data !== 32'h0) || (rsp_err !== 1'b0) || (eng_req !== 1'b0) || (eng_wdata !== 32'h0) || (busy !== 1'b1) || (req_ready !== '0);
        checks++; if (bad) begin errors++; $display("FAIL mid_reset_vals: got v=%b id=%0d d=%h e=%b er=%b wd=%h busy=%b rr=%b", rsp_valid, rsp_id, rsp_data, rsp_err, eng_req, eng_wdata, busy, req_ready); end
        @(negedge clk); rstb = 1'b1; #1;
        bad = 1'b0; saw_ack = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (req_ready !== '0) bad = 1'b1;
            if (eng_ack === 1'b1) begin saw_ack = 1'b1; break; end
            @(negedge clk); #1;
        end
        checks++; if (bad || !saw_ack) begin errors++; $display("FAIL mid_drain: got early_grant=%b saw_ack=%b want 0 1", bad, saw_ack); end
        @(negedge clk); #1;
        t0 = cyc;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_regrant: got %b want 0100", req_ready); end
        @(negedge clk); req_valid = '0;
        wait_rsp(30, ok);
        checks++; if (!ok || (cyc - t0) !== 11 || rsp_id !== 2'd2 || rsp_data !== enc(32'hCAFE_F00D)) begin errors++; $display("FAIL mid_rsp: got dt=%0d id=%0d data=%h want 11 2 %h", cyc - t0, rsp_id, rsp_data, enc(32'hCAFE_F00D)); end
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_stall();
        test_reset_midjob();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish by 200000");
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
